// File: rtl/gdo_backprop_neuron.sv
// gdo_backprop_neuron
//   Backward-pass engine for one neuron in the gdo fixed-point format. The format is a signed
//   DATA_W-bit word with FRAC_W fractional bits, so one = 1 << FRAC_W.
//
//   At start it latches y, err and lr. It then forms the activation derivative d and the local
//   gradient delta = err * d, and the scaled step s = lr * delta. After that it streams N_IN
//   (x, w) beats and returns w' = w - s * x for each one.
//
//   Optional feature: define GDO_BP_SATURATE_EN to clamp every narrowing to the signed DATA_W
//   range. When it is undefined, narrowing wraps (keeps the low DATA_W bits).
//
// Ports
//   clk, rst_n                  clock (rising edge), asynchronous active-low reset
//   start_valid / start_ready   job handshake; y_in, err_in, lr_in are sampled on accept
//   x_valid / x_ready           beat handshake for x_in, w_in and x_last
//   upd_valid / upd_ready       updated-weight handshake for w_out and upd_idx
//   grad_out                    local gradient delta, held until it is recomputed
//   busy, done, err_flag        status: not idle, end-of-job pulse, sticky x_last mismatch
module gdo_backprop_neuron #(
    parameter int DATA_W = 17,
    parameter int FRAC_W = 8,
    parameter int N_IN   = 4,
    parameter int ACT    = 0
) (
    input  logic                                             clk,
    input  logic                                             rst_n,
    input  logic                                             start_valid,
    output logic                                             start_ready,
    input  logic signed [DATA_W-1:0]                         y_in,
    input  logic signed [DATA_W-1:0]                         err_in,
    input  logic signed [DATA_W-1:0]                         lr_in,
    input  logic                                             x_valid,
    output logic                                             x_ready,
    input  logic signed [DATA_W-1:0]                         x_in,
    input  logic signed [DATA_W-1:0]                         w_in,
    input  logic                                             x_last,
    output logic                                             upd_valid,
    input  logic                                             upd_ready,
    output logic signed [DATA_W-1:0]                         w_out,
    output logic [($clog2(N_IN) > 1 ? $clog2(N_IN) : 1)-1:0] upd_idx,
    output logic signed [DATA_W-1:0]                         grad_out,
    output logic                                             busy,
    output logic                                             done,
    output logic                                             err_flag
);

    localparam int IDX_W = ($clog2(N_IN) > 1) ? $clog2(N_IN) : 1;
    // Wide enough for the full product of two (DATA_W+1)-bit operands.
    localparam int PW    = 2 * DATA_W + 2;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_DERIV  = 3'd1;
    localparam logic [2:0] ST_DELTA  = 3'd2;
    localparam logic [2:0] ST_STREAM = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    localparam logic signed [DATA_W:0] ONE =
        {{(DATA_W - FRAC_W){1'b0}}, 1'b1, {FRAC_W{1'b0}}};

    typedef logic signed [PW-1:0] wide_t;

    function automatic logic signed [DATA_W-1:0] narrow(input wide_t v);
`ifdef GDO_BP_SATURATE_EN
        wide_t maxv;
        wide_t minv;
        maxv = {{(PW - DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
        minv = ~maxv;
        if (v > maxv) begin
            return maxv[DATA_W-1:0];
        end else if (v < minv) begin
            return minv[DATA_W-1:0];
        end
        return v[DATA_W-1:0];
`else
        return v[DATA_W-1:0];
`endif
    endfunction

    function automatic logic signed [DATA_W:0] sx(input logic signed [DATA_W-1:0] a);
        return {a[DATA_W-1], a};
    endfunction

    // Fixed-point multiply. The arithmetic shift floors toward minus infinity.
    function automatic logic signed [DATA_W-1:0] mul(input logic signed [DATA_W:0] a,
                                                     input logic signed [DATA_W:0] b);
        wide_t p;
        p = wide_t'(a) * wide_t'(b);
        return narrow(p >>> FRAC_W);
    endfunction

    function automatic logic signed [DATA_W-1:0] sub_n(input logic signed [DATA_W:0] a,
                                                       input logic signed [DATA_W:0] b);
        return narrow(wide_t'(a) - wide_t'(b));
    endfunction

    logic [2:0]               state_q, state_d;
    logic signed [DATA_W-1:0] y_q, y_d, err_q, err_d, lr_q, lr_d;
    logic signed [DATA_W-1:0] d_q, d_d, grad_q, grad_d, s_q, s_d;
    logic signed [DATA_W-1:0] w_out_q, w_out_d;
    logic [IDX_W-1:0]         cnt_q, cnt_d, upd_idx_q, upd_idx_d;
    logic                     all_in_q, all_in_d;
    logic                     upd_valid_q, upd_valid_d;
    logic                     err_flag_q, err_flag_d;

    logic signed [DATA_W-1:0] d_calc, grad_calc, s_calc, w_calc;
    logic                     beat_fire, drain, last_beat;

    assign start_ready = (state_q == ST_IDLE);
    // Once the final beat has been taken, no further beats are accepted.
    assign x_ready     = (state_q == ST_STREAM) && !all_in_q && (!upd_valid_q || upd_ready);
    assign beat_fire   = x_valid && x_ready;
    assign drain       = upd_valid_q && upd_ready;
    assign last_beat   = (cnt_q == IDX_W'(N_IN - 1));

    assign upd_valid   = upd_valid_q;
    assign w_out       = w_out_q;
    assign upd_idx     = upd_idx_q;
    assign grad_out    = grad_q;
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign err_flag    = err_flag_q;

    always_comb begin
        if (ACT == 0) begin
            d_calc = mul(sx(y_q), ONE - sx(y_q));
        end else if (ACT == 1) begin
            d_calc = sub_n(ONE, sx(mul(sx(y_q), sx(y_q))));
        end else begin
            // Straight-through estimator: the gradient passes unchanged.
            d_calc = ONE[DATA_W-1:0];
        end
        grad_calc = mul(sx(err_q), sx(d_q));
        s_calc    = mul(sx(lr_q), sx(grad_calc));
        w_calc    = sub_n(sx(w_in), sx(mul(sx(s_q), sx(x_in))));
    end

    always_comb begin
        state_d     = state_q;
        y_d         = y_q;
        err_d       = err_q;
        lr_d        = lr_q;
        d_d         = d_q;
        grad_d      = grad_q;
        s_d         = s_q;
        w_out_d     = w_out_q;
        cnt_d       = cnt_q;
        upd_idx_d   = upd_idx_q;
        all_in_d    = all_in_q;
        upd_valid_d = upd_valid_q;
        err_flag_d  = err_flag_q;

        case (state_q)
            ST_IDLE: begin
                if (start_valid) begin
                    state_d    = ST_DERIV;
                    y_d        = y_in;
                    err_d      = err_in;
                    lr_d       = lr_in;
                    cnt_d      = '0;
                    all_in_d   = 1'b0;
                    err_flag_d = 1'b0;
                end
            end
            ST_DERIV: begin
                d_d     = d_calc;
                state_d = ST_DELTA;
            end
            ST_DELTA: begin
                grad_d  = grad_calc;
                s_d     = s_calc;
                state_d = ST_STREAM;
            end
            ST_STREAM: begin
                if (drain) begin
                    upd_valid_d = 1'b0;
                end
                // A new update can load in the same cycle as the previous one drains.
                if (beat_fire) begin
                    upd_valid_d = 1'b1;
                    w_out_d     = w_calc;
                    upd_idx_d   = cnt_q;
                    if (last_beat) begin
                        cnt_d    = '0;
                        all_in_d = 1'b1;
                        if (!x_last) begin
                            err_flag_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        if (x_last) begin
                            err_flag_d = 1'b1;
                        end
                    end
                end
                if (all_in_q && drain) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            y_q         <= '0;
            err_q       <= '0;
            lr_q        <= '0;
            d_q         <= '0;
            grad_q      <= '0;
            s_q         <= '0;
            w_out_q     <= '0;
            cnt_q       <= '0;
            upd_idx_q   <= '0;
            all_in_q    <= 1'b0;
            upd_valid_q <= 1'b0;
            err_flag_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            y_q         <= y_d;
            err_q       <= err_d;
            lr_q        <= lr_d;
            d_q         <= d_d;
            grad_q      <= grad_d;
            s_q         <= s_d;
            w_out_q     <= w_out_d;
            cnt_q       <= cnt_d;
            upd_idx_q   <= upd_idx_d;
            all_in_q    <= all_in_d;
            upd_valid_q <= upd_valid_d;
            err_flag_q  <= err_flag_d;
        end
    end

endmodule

// File: tb/tb_gdo_backprop_neuron.sv
// Directed bench for gdo_backprop_neuron. It drives one instance for each activation type
// (sigmoid, tanh, binary) from the same stimulus, and checks the instance selected by sel.
`timescale 1ns/1ps
module tb_gdo_backprop_neuron;

    localparam int DATA_W = 17;
    localparam int FRAC_W = 8;
    localparam int N_IN   = 4;
    localparam int IDX_W  = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                     start_valid, x_valid, x_last, upd_ready;
    logic signed [DATA_W-1:0] y_in, err_in, lr_in, x_in, w_in;

    logic                     start_ready_a [3];
    logic                     x_ready_a     [3];
    logic                     upd_valid_a   [3];
    logic signed [DATA_W-1:0] w_out_a       [3];
    logic [IDX_W-1:0]         upd_idx_a     [3];
    logic signed [DATA_W-1:0] grad_out_a    [3];
    logic                     busy_a        [3];
    logic                     done_a        [3];
    logic                     err_flag_a    [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        gdo_backprop_neuron #(
            .DATA_W(DATA_W),
            .FRAC_W(FRAC_W),
            .N_IN  (N_IN),
            .ACT   (g)
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .start_valid(start_valid),
            .start_ready(start_ready_a[g]),
            .y_in       (y_in),
            .err_in     (err_in),
            .lr_in      (lr_in),
            .x_valid    (x_valid),
            .x_ready    (x_ready_a[g]),
            .x_in       (x_in),
            .w_in       (w_in),
            .x_last     (x_last),
            .upd_valid  (upd_valid_a[g]),
            .upd_ready  (upd_ready),
            .w_out      (w_out_a[g]),
            .upd_idx    (upd_idx_a[g]),
            .grad_out   (grad_out_a[g]),
            .busy       (busy_a[g]),
            .done       (done_a[g]),
            .err_flag   (err_flag_a[g])
        );
    end

    int errors = 0;
    int checks = 0;
    int sel = 0;
    int done_seen = 0;

    always @(negedge clk) begin
        if (done_a[sel]) done_seen <= done_seen + 1;
    end

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Run one job on instance s. If stall is set, upd_ready is held low for three cycles
    // after beat 0. If abort_at is a valid beat index, reset is pulsed while that beat is
    // presented.
    task automatic run_job(input int s, input int y, input int err, input int lr,
                           input int xs[4], input int ws[4], input int exp_w[4],
                           input logic [3:0] lasts, input int exp_grad, input bit stall,
                           input bit exp_err, input int abort_at);
        int done0;
        sel = s;
        #1;
        check("idle_before_start", start_ready_a[sel], 1);
        start_valid = 1'b1;
        y_in        = DATA_W'(y);
        err_in      = DATA_W'(err);
        lr_in       = DATA_W'(lr);
        upd_ready   = !stall;
        @(posedge clk); #1;
        // Change the inputs after accept; start_valid stays high to show it is ignored.
        y_in   = DATA_W'(12345);
        err_in = DATA_W'(-777);
        lr_in  = DATA_W'(999);
        check("busy_after_start", busy_a[sel], 1);
        check("start_ready_busy", start_ready_a[sel], 0);
        check("err_flag_cleared", err_flag_a[sel], 0);
        check("x_ready_deriv", x_ready_a[sel], 0);
        @(posedge clk); #1;
        check("x_ready_delta", x_ready_a[sel], 0);
        @(posedge clk); #1;
        check("x_ready_latency", x_ready_a[sel], 1);
        check("grad_out", grad_out_a[sel], exp_grad);
        done0   = done_seen;
        x_valid = 1'b1;
        for (int i = 0; i < N_IN; i++) begin
            x_in   = DATA_W'(xs[i]);
            w_in   = DATA_W'(ws[i]);
            x_last = lasts[i];
            #1;
            if (i == abort_at) begin
                rst_n = 1'b0;
                #1;
                check("rst_upd_valid", upd_valid_a[sel], 0);
                check("rst_w_out", w_out_a[sel], 0);
                check("rst_upd_idx", upd_idx_a[sel], 0);
                check("rst_grad_out", grad_out_a[sel], 0);
                check("rst_busy", busy_a[sel], 0);
                check("rst_x_ready", x_ready_a[sel], 0);
                x_valid     = 1'b0;
                start_valid = 1'b0;
                x_last      = 1'b0;
                @(posedge clk); #1;
                rst_n = 1'b1;
                @(posedge clk); #1;
                check("rst_start_ready", start_ready_a[sel], 1);
                check("rst_no_done", done_seen - done0, 0);
                check("rst_err_flag", err_flag_a[sel], 0);
                return;
            end
            if (stall && i == 1) begin
                repeat (3) begin
                    check("stall_x_ready", x_ready_a[sel], 0);
                    check("stall_upd_valid", upd_valid_a[sel], 1);
                    check("stall_w_out", w_out_a[sel], exp_w[0]);
                    check("stall_upd_idx", upd_idx_a[sel], 0);
                    @(posedge clk); #1;
                end
                upd_ready = 1'b1;
                #1;
            end
            check("x_ready_beat", x_ready_a[sel], 1);
            @(posedge clk); #1;
            check("upd_valid", upd_valid_a[sel], 1);
            check("w_out", w_out_a[sel], exp_w[i]);
            check("upd_idx", upd_idx_a[sel], i);
        end
        x_valid     = 1'b0;
        x_last      = 1'b0;
        start_valid = 1'b0;
        check("err_flag", err_flag_a[sel], exp_err);
        @(posedge clk); #1;
        check("done_pulse", done_a[sel], 1);
        check("upd_drained", upd_valid_a[sel], 0);
        check("grad_held", grad_out_a[sel], exp_grad);
        @(posedge clk); #1;
        check("done_low", done_a[sel], 0);
        check("idle_after_done", start_ready_a[sel], 1);
        check("done_once", done_seen - done0, 1);
        check("err_flag_sticky", err_flag_a[sel], exp_err);
    endtask

    initial begin
        int exp_sat;
        start_valid = 1'b0;
        x_valid     = 1'b0;
        x_last      = 1'b0;
        upd_ready   = 1'b1;
        y_in        = '0;
        err_in      = '0;
        lr_in       = '0;
        x_in        = '0;
        w_in        = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_start_ready", start_ready_a[0], 1);
        check("reset_upd_valid", upd_valid_a[0], 0);
        check("reset_w_out", w_out_a[0], 0);
        check("reset_upd_idx", upd_idx_a[0], 0);
        check("reset_grad_out", grad_out_a[0], 0);
        check("reset_done", done_a[0], 0);
        check("reset_err_flag", err_flag_a[0], 0);
        check("reset_busy", busy_a[0], 0);
        check("reset_x_ready", x_ready_a[0], 0);
        rst_n = 1'b1;
        @(posedge clk);

`ifdef GDO_BP_SATURATE_EN
        exp_sat = 65535;
`else
        exp_sat = -63512;
`endif
        // Sigmoid: d=64, delta=64, s=64; the last beat checks the floor of -0.25.
        run_job(0, 128, 256, 256, '{256, 512, -256, -1}, '{512, 0, 100, 0},
                '{448, -128, 164, 1}, 4'b1000, 64, 1'b0, 1'b0, -1);
        // Tanh: d=192, delta=192, s=96; backpressure after the first update.
        run_job(1, 128, 256, 128, '{512, 256, -512, 768}, '{0, 256, 0, 1000},
                '{-192, 160, 192, 712}, 4'b1000, 192, 1'b1, 1'b0, -1);
        // Binary: delta=-256, s=-256; overflow on beat 0; x_last is early on beat 1.
        run_job(2, 0, -256, 256, '{2560, 256, 0, -256}, '{65000, 10, -5, 0},
                '{exp_sat, 266, -5, -256}, 4'b1010, -256, 1'b0, 1'b1, -1);
        check("err_flag_before_restart", err_flag_a[0], 1);
        // Sigmoid y=64: d=48, delta=96, s=48; reset while beat 2 is presented.
        run_job(0, 64, 512, 128, '{256, 512, 256, 256}, '{0, 0, 0, 0},
                '{-48, -96, -48, -48}, 4'b1000, 96, 1'b0, 1'b0, 2);
        // A full job after the abort; x_last is missing on the final beat.
        run_job(0, 128, 256, 256, '{256, 512, -256, -1}, '{512, 0, 100, 0},
                '{448, -128, 164, 1}, 4'b0000, 64, 1'b0, 1'b1, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
